// File: rtl/tick_rate_gen.sv
// -----------------------------------------------------------------------------
// tick_rate_gen
//
// Upstream stage of the LED shift register. Turns raw board switches into a
// periodic one-cycle strobe plus a clean direction level. The strobe period is
// chosen from four programmable values by a 2-bit select code.
//
// Ports:
//   clock    - system clock, all logic on the rising edge
//   i_reset  - asynchronous, active-high reset
//   i_sw     - raw switches: [0] run enable, [2:1] period select, [3] direction
//   o_valid  - registered one-cycle strobe (feeds shift register i_valid)
//   o_dir    - direction level, 1 = shift left, 0 = shift right (feeds i_sw)
//   o_sel    - period select code currently in force
//
// Optional feature:
//   DEBOUNCE_EN - when defined, the synchronized direction switch passes through
//                 a debouncer. A new value reaches o_dir only after it has been
//                 stable for 2**NB_DEBOUNCE consecutive cycles. When undefined,
//                 o_dir is the synchronized direction registered once and
//                 NB_DEBOUNCE is unused.
// -----------------------------------------------------------------------------
module tick_rate_gen #(
   parameter int          NB_COUNTER  = 32,
   parameter int          NB_SW       = 4,
   parameter int unsigned LIMIT_REF0  = 2**20,
   parameter int unsigned LIMIT_REF1  = 2**22,
   parameter int unsigned LIMIT_REF2  = 2**24,
   parameter int unsigned LIMIT_REF3  = 2**26,
   parameter int          NB_DEBOUNCE = 16
) (
   input  logic             clock,
   input  logic             i_reset,
   input  logic [NB_SW-1:0] i_sw,
   output logic             o_valid,
   output logic             o_dir,
   output logic [1:0]       o_sel
);

   // Terminal count for each select code. The counter compares against
   // LIMIT-1 so the pulse spacing is exactly LIMIT cycles.
   localparam logic [NB_COUNTER-1:0] LIMIT0_M1 = NB_COUNTER'(LIMIT_REF0 - 1);
   localparam logic [NB_COUNTER-1:0] LIMIT1_M1 = NB_COUNTER'(LIMIT_REF1 - 1);
   localparam logic [NB_COUNTER-1:0] LIMIT2_M1 = NB_COUNTER'(LIMIT_REF2 - 1);
   localparam logic [NB_COUNTER-1:0] LIMIT3_M1 = NB_COUNTER'(LIMIT_REF3 - 1);

   // Elaboration-time guards on configurations the counter cannot honour.
   if (LIMIT_REF0 < 2 || LIMIT_REF1 < 2 || LIMIT_REF2 < 2 || LIMIT_REF3 < 2) begin : g_bad_limit
      $error("tick_rate_gen: every LIMIT_REFx must be at least 2");
   end
   if (NB_DEBOUNCE < 1) begin : g_bad_nb_debounce
      $error("tick_rate_gen: NB_DEBOUNCE must be at least 1");
   end

   logic [NB_SW-1:0]      sw_meta_q, sw_meta_d;
   logic [NB_SW-1:0]      sw_sync_q, sw_sync_d;
   logic                  en_s;
   logic                  dir_s;
   logic [1:0]            sel_s;

   logic [NB_COUNTER-1:0] cnt_q, cnt_d;
   logic [NB_COUNTER-1:0] limit_m1;
   logic                  valid_q, valid_d;
   logic [1:0]            sel_q, sel_d;
   logic                  dir_q, dir_d;

   // Two-flop synchronizer on every switch bit; nothing downstream looks at
   // the raw switches.
   always_comb begin
      sw_meta_d = i_sw;
      sw_sync_d = sw_meta_q;
   end

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
      end
   end

   assign en_s  = sw_sync_q[0];
   assign sel_s = sw_sync_q[2:1];
   assign dir_s = sw_sync_q[3];

   // The period in force follows o_sel, not the live select switches, so a
   // select change while running cannot shorten or stretch the current period.
   always_comb begin
      limit_m1 = LIMIT0_M1;
      case (sel_q)
         2'd0: limit_m1 = LIMIT0_M1;
         2'd1: limit_m1 = LIMIT1_M1;
         2'd2: limit_m1 = LIMIT2_M1;
         2'd3: limit_m1 = LIMIT3_M1;
         default: limit_m1 = LIMIT0_M1;
      endcase
   end

   // Period counter. While paused the count is frozen and the select code
   // tracks the switches directly; while running the select is only reloaded
   // at the terminal count. If enable drops on the terminal cycle the count
   // simply holds at LIMIT-1 and the pulse fires once enable returns.
   // The >= compare only matters if a pause-time select change leaves the
   // held count beyond the new terminal value: it then ends the period at
   // once instead of running the counter through its full range.
   always_comb begin
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      sel_d   = sel_q;
      if (en_s) begin
         if (cnt_q >= limit_m1) begin
            cnt_d   = '0;
            valid_d = 1'b1;
            sel_d   = sel_s;
         end else begin
            cnt_d   = cnt_q + NB_COUNTER'(1);
         end
      end else begin
         sel_d = sel_s;
      end
   end

`ifdef DEBOUNCE_EN
   logic                   cand_q, cand_d;
   logic [NB_DEBOUNCE-1:0] db_cnt_q, db_cnt_d;

   // cand_q is the previous synchronized direction sample. db_cnt_q counts
   // how many further cycles it has stayed unchanged while differing from
   // o_dir; reaching all-ones means 2**NB_DEBOUNCE stable samples, so the
   // candidate is accepted. Any toggle, or agreement with o_dir, clears it.
   always_comb begin
      cand_d   = dir_s;
      db_cnt_d = '0;
      dir_d    = dir_q;
      if (cand_q != dir_q) begin
         if (db_cnt_q == '1) begin
            dir_d = cand_q;
         end else if (dir_s == cand_q) begin
            db_cnt_d = db_cnt_q + NB_DEBOUNCE'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         cand_q   <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         cand_q   <= cand_d;
         db_cnt_q <= db_cnt_d;
      end
   end
`else
   always_comb begin
      dir_d = dir_s;
   end
`endif

   // Output and counter state.
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
         sel_q   <= 2'd0;
         dir_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         sel_q   <= sel_d;
         dir_q   <= dir_d;
      end
   end

   assign o_valid = valid_q;
   assign o_dir   = dir_q;
   assign o_sel   = sel_q;

endmodule

// File: tb/tb_tick_rate_gen.sv
// -----------------------------------------------------------------------------
// tb_tick_rate_gen
//
// Directed bench for tick_rate_gen with periods 4/8/16/32 and a 3-bit
// debounce counter. A behavioural model driven from the switch history is
// compared against the DUT on every falling edge, and the directed sequence
// adds hand-computed latency/spacing expectations.
// -----------------------------------------------------------------------------
module tb_tick_rate_gen;

   logic       clock = 1'b0;
   logic       i_reset;
   logic [3:0] i_sw;
   logic       o_valid;
   logic       o_dir;
   logic [1:0] o_sel;

   int passCount  = 0;
   int checkCount = 0;

   int periods [4] = '{4, 8, 16, 32};

   always #5 clock = ~clock;

   tick_rate_gen #(
      .NB_COUNTER  (32),
      .NB_SW       (4),
      .LIMIT_REF0  (4),
      .LIMIT_REF1  (8),
      .LIMIT_REF2  (16),
      .LIMIT_REF3  (32),
      .NB_DEBOUNCE (3)
   ) dut (
      .clock   (clock),
      .i_reset (i_reset),
      .i_sw    (i_sw),
      .o_valid (o_valid),
      .o_dir   (o_dir),
      .o_sel   (o_sel)
   );

   // Generic comparison: counts every check and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end else begin
         passCount++;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] sw);
      i_sw = sw;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Advances until o_valid is seen high after an edge, or the budget runs out.
   task automatic waitPulse(input int maxCycles, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (o_valid !== 1'b1 && cycles < maxCycles);
   endtask

   // Behavioural model. swHist[k] is the switch value of the cycle k+1 before
   // the one about to start; the design sees switches three cycles late
   // (two synchronizer stages plus the output register). progress counts the
   // enabled cycles spent in the current period.
   logic [3:0] swHist [0:10];
   logic [3:0] modelSw;
   int         progress  = 0;
   logic       expValid  = 1'b0;
   logic       expDir    = 1'b0;
   logic [1:0] expSel    = 2'd0;
   logic       stable;

   always @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         for (int k = 0; k <= 10; k++) swHist[k] = 4'b0000;
         progress = 0;
         expValid = 1'b0;
         expDir   = 1'b0;
         expSel   = 2'd0;
      end else begin
         for (int k = 10; k > 0; k--) swHist[k] = swHist[k-1];
         swHist[0] = i_sw;
         modelSw   = swHist[2];
         if (modelSw[0]) begin
            progress++;
            if (progress == periods[expSel]) begin
               expValid = 1'b1;
               progress = 0;
               expSel   = modelSw[2:1];
            end else begin
               expValid = 1'b0;
            end
         end else begin
            expValid = 1'b0;
            expSel   = modelSw[2:1];
         end
`ifdef DEBOUNCE_EN
         stable = 1'b1;
         for (int k = 4; k <= 10; k++) begin
            if (swHist[k][3] != swHist[3][3]) stable = 1'b0;
         end
         if (stable && swHist[3][3] != expDir) expDir = swHist[3][3];
`else
         expDir = modelSw[3];
`endif
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clock) begin
      checkOutput("cyc_valid", 32'(o_valid), 32'(expValid));
      checkOutput("cyc_sel",   32'(o_sel),   32'(expSel));
      checkOutput("cyc_dir",   32'(o_dir),   32'(expDir));
   end

   int c;

   initial begin
      i_reset = 1'b1;
      i_sw    = 4'b0000;
      repeat (3) tick();
      checkOutput("rst_valid", 32'(o_valid), 32'd0);
      checkOutput("rst_sel",   32'(o_sel),   32'd0);
      checkOutput("rst_dir",   32'(o_dir),   32'd0);

      // Run at select 0: first pulse after 2 sync cycles plus 4, then every 4.
      i_reset = 1'b0;
      applyStimulus(4'b0001);
      waitPulse(20, c);
      checkOutput("first_pulse_latency", 32'(c), 32'd6);
      checkOutput("sel0_on_pulse", 32'(o_sel), 32'd0);
      tick();
      checkOutput("pulse_one_wide", 32'(o_valid), 32'd0);
      waitPulse(20, c);
      checkOutput("sel0_spacing", 32'(c + 1), 32'd4);
      waitPulse(20, c);
      checkOutput("sel0_spacing2", 32'(c), 32'd4);

      // Select moved to 3 at counter=1: current period still 4, then 32.
      tick();
      applyStimulus(4'b0111);
      waitPulse(20, c);
      checkOutput("sel_change_spacing", 32'(c + 1), 32'd4);
      checkOutput("sel3_on_pulse", 32'(o_sel), 32'd3);
      applyStimulus(4'b0011);
      waitPulse(40, c);
      checkOutput("sel3_spacing", 32'(c), 32'd32);
      checkOutput("sel1_on_pulse", 32'(o_sel), 32'd1);
      waitPulse(20, c);
      checkOutput("sel1_spacing", 32'(c), 32'd8);

      // Pause for 10 cycles starting at counter=2; 6 enabled cycles remain.
      applyStimulus(4'b0010);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("pause_no_pulse", 32'(o_valid), 32'd0);
      end
      applyStimulus(4'b0011);
      waitPulse(20, c);
      checkOutput("resume_latency", 32'(c), 32'd8);

      // Enable low exactly on the terminal cycle: count holds at 7.
      repeat (5) tick();
      applyStimulus(4'b0010);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("term_pause_no_pulse", 32'(o_valid), 32'd0);
      end
      applyStimulus(4'b0011);
      waitPulse(20, c);
      checkOutput("term_resume_latency", 32'(c), 32'd3);
      waitPulse(20, c);
      checkOutput("term_resume_spacing", 32'(c), 32'd8);

      // Direction: two 3-cycle glitches, then held high.
      for (int g = 0; g < 2; g++) begin
         applyStimulus(4'b1011);
         repeat (2) tick();
         checkOutput("glitch_dir_early", 32'(o_dir), 32'd0);
         tick();
`ifdef DEBOUNCE_EN
         checkOutput("glitch_dir_filtered", 32'(o_dir), 32'd0);
`else
         checkOutput("glitch_dir_follow", 32'(o_dir), 32'd1);
`endif
         applyStimulus(4'b0011);
         repeat (3) tick();
         checkOutput("glitch_dir_back", 32'(o_dir), 32'd0);
      end
      applyStimulus(4'b1011);
      repeat (10) tick();
`ifdef DEBOUNCE_EN
      checkOutput("hold_dir_before_accept", 32'(o_dir), 32'd0);
`else
      checkOutput("hold_dir_follow", 32'(o_dir), 32'd1);
`endif
      tick();
      checkOutput("hold_dir_accepted", 32'(o_dir), 32'd1);

      // Asynchronous reset in the middle of a pulse cycle.
      waitPulse(20, c);
      checkOutput("pre_reset_valid", 32'(o_valid), 32'd1);
      checkOutput("pre_reset_dir",   32'(o_dir),   32'd1);
      checkOutput("pre_reset_sel",   32'(o_sel),   32'd1);
      #1;
      i_reset = 1'b1;
      #1;
      checkOutput("async_rst_valid", 32'(o_valid), 32'd0);
      checkOutput("async_rst_dir",   32'(o_dir),   32'd0);
      checkOutput("async_rst_sel",   32'(o_sel),   32'd0);
      tick();
      i_reset = 1'b0;
      waitPulse(20, c);
      checkOutput("post_reset_latency", 32'(c), 32'd6);
      checkOutput("post_reset_sel", 32'(o_sel), 32'd1);
      waitPulse(20, c);
      checkOutput("post_reset_spacing", 32'(c), 32'd8);

      tick();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/tick_rate_gen.md
Name: tick_rate_gen

Overview:
- Upstream stage of the LED shift register.
- Turns raw board switches into a periodic one-cycle `o_valid` strobe and a clean direction level.
- The strobe rate is selected from four programmable periods.
- Outputs connect directly to the shift register's `i_valid` and `i_sw` inputs.

Parameters:
- NB_COUNTER, 32, width of the period counter.
- NB_SW, 4, width of the switch bus.
- LIMIT_REF0, 2**20, period in clock cycles for select code 0.
- LIMIT_REF1, 2**22, period for select code 1.
- LIMIT_REF2, 2**24, period for select code 2.
- LIMIT_REF3, 2**26, period for select code 3.
- NB_DEBOUNCE, 16, width of the debounce counter (used only with DEBOUNCE_EN).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_sw  input  NB_SW  raw switches:
  - [0] run enable
  - [2:1] period select
  - [3] direction
- o_valid  output  1  one-cycle strobe, registered.
- o_dir  output  1  direction level; 1 = shift left, 0 = shift right.
- o_sel  output  2  period select code currently in force.

Behaviour:
- Reset: on `i_reset`=1, immediately and asynchronously:
  - `o_valid`=0, `o_dir`=0, `o_sel`=0.
  - counter=0.
  - Synchronizer flops=0; debounce state=0.
- Synchronizer: each `i_sw` bit passes through two flops. All logic below uses only the synchronized copies: en_s, sel_s, dir_s. Switch-to-internal latency is 2 cycles.
- Active period: LIMIT = LIMIT_REF[o_sel]. Every LIMIT_REFx must be >= 2; smaller values are unsupported.
- Counting (en_s=1):
  - Counter increments each cycle.
  - When counter == LIMIT-1:
    - counter <= 0.
    - `o_valid` <= 1 for exactly the next cycle.
    - `o_sel` <= sel_s.
  - The steady pulse spacing is exactly LIMIT cycles.
  - The first pulse occurs LIMIT cycles after the first cycle with en_s=1, counting from counter=0.
- Pause (en_s=0):
  - Counter holds its value.
  - `o_valid`=0.
  - `o_sel` <= sel_s every cycle.
  - When en_s returns to 1, counting resumes from the held value; there is no restart.
- Select change while running: takes effect only at the terminal count, so no period is ever truncated or extended mid-count.
- Enable falling on the terminal-count cycle: pause wins. No pulse is issued, and the counter holds at LIMIT-1. The pulse fires on the first enabled cycle after resume.
- Width: counter compare uses NB_COUNTER bits. LIMIT_REFx must fit in NB_COUNTER; the counter never wraps through 2**NB_COUNTER.
- `o_dir`: registered from dir_s, or from the debounced value under DEBOUNCE_EN. It may change on any cycle.
- Reset mid-count: all state clears. After release, the first pulse needs 2 synchronizer cycles plus a full LIMIT_REF0 period.

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined:
  - dir_s feeds a debouncer. A candidate value is accepted into `o_dir` only after it has been stable for 2**NB_DEBOUNCE consecutive cycles.
  - Any toggle restarts the debounce counter.
  - Debouncer resets to 0 with `o_dir`.
- Undefined:
  - `o_dir` = dir_s registered once: 3 cycles after `i_sw[3]`.
  - NB_DEBOUNCE is unused.

Test Plan (bench overrides LIMIT_REF0..3 = 4, 8, 16, 32; NB_DEBOUNCE = 3):
- Reset asserted asynchronously mid-cycle -> `o_valid`, `o_dir`, `o_sel` go to 0 before the next clock edge.
- `i_sw`=4'b0001 held after reset -> `o_valid` pulses 1 cycle wide, exactly every 4 cycles; `o_sel`=0.
- Running at sel=0, `i_sw[2:1]` changed to 2'b11 at counter=1 -> next pulse still 4 cycles after the previous one. `o_sel`=3 on that pulse cycle; subsequent spacing is 32.
- `i_sw[0]` dropped for 10 cycles at counter=2 of sel=1 -> no pulse during the pause. The pulse comes 6 enabled cycles after resume.
- Enable dropped so en_s=0 exactly on the terminal-count cycle -> no pulse; counter holds at 7. The pulse occurs on the first enabled cycle after resume.
- DEBOUNCE_EN: `i_sw[3]` toggled with 3-cycle glitches -> `o_dir` stays 0. Held high for 8 or more cycles -> `o_dir`=1 after 2 + 8 + 1 cycles. Without the macro -> `o_dir` follows each glitch 3 cycles late.
